// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, follower FSM states and a width helper.
package maze_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1; never returns less than 1.
    function automatic int BITS(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/move_unit.sv
// Combinational single-step move on the maze grid; coordinates wrap, with a flag
// raised when the step would leave the grid.
module move_unit
    import maze_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int WIDTH    = 2
) (
    input  logic [ROW_BITS-1:0] row,
    input  logic [COL_BITS-1:0] col,
    input  logic [WIDTH-1:0]    dir,
    output logic [ROW_BITS-1:0] next_row,
    output logic [COL_BITS-1:0] next_col,
    output logic                out_of_bounds
);

    always_comb begin
        next_row      = row;
        next_col      = col;
        out_of_bounds = 1'b0;
        case (dir)
            WIDTH'(DIR_UP): begin
                next_row      = row - ROW_BITS'(1);
                out_of_bounds = (row == '0);
            end
            WIDTH'(DIR_RIGHT): begin
                next_col      = col + COL_BITS'(1);
                out_of_bounds = (col == '1);
            end
            WIDTH'(DIR_DOWN): begin
                next_row      = row + ROW_BITS'(1);
                out_of_bounds = (row == '1);
            end
            WIDTH'(DIR_LEFT): begin
                next_col      = col - COL_BITS'(1);
                out_of_bounds = (col == '0);
            end
            default: begin
                next_row      = row;
                next_col      = col;
                out_of_bounds = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/path_follower.sv
// Walks the maze grid from a start cell following a stream of direction beats.
// Define PATH_BOUND_CHECK_EN to abort the run on a move that leaves the grid.
module path_follower
    import maze_pkg::*;
#(
    parameter  int ROW_BITS  = 4,
    parameter  int COL_BITS  = 4,
    parameter  int WIDTH     = 2,
    parameter  int MAX_STEPS = 256,
    localparam int CNT_W     = BITS(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ROW_BITS-1:0] start_row,
    input  logic [COL_BITS-1:0] start_col,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_dir,
    input  logic                in_last,
    output logic                in_ready,
    output logic                pos_valid,
    output logic [ROW_BITS-1:0] pos_row,
    output logic [COL_BITS-1:0] pos_col,
    output logic [CNT_W-1:0]    step_count,
    output logic                done,
    output logic                error
);

`ifdef PATH_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pos_valid_q, pos_valid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [ROW_BITS-1:0]   next_row;
    logic [COL_BITS-1:0]   next_col;
    logic                  out_of_bounds;
    logic                  accept;

    move_unit #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .WIDTH    (WIDTH)
    ) u_move (
        .row           (row_q),
        .col           (col_q),
        .dir           (in_dir),
        .next_row      (next_row),
        .next_col      (next_col),
        .out_of_bounds (out_of_bounds)
    );

    // A start in the same cycle wins over any offered beat.
    assign in_ready = (state_q == RUN) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        pos_valid_d = 1'b0;
        done_d      = done_q;
        error_d     = error_q;
        if (start) begin
            state_d = RUN;
            row_d   = start_row;
            col_d   = start_col;
            cnt_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else if (accept) begin
            if (cnt_q == CNT_W'(MAX_STEPS) || (BOUND_CHECK && out_of_bounds)) begin
                state_d = ERR;
                error_d = 1'b1;
            end else begin
                row_d       = next_row;
                col_d       = next_col;
                cnt_d       = cnt_q + CNT_W'(1);
                pos_valid_d = 1'b1;
                if (in_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            pos_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            pos_valid_q <= pos_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign pos_valid  = pos_valid_q;
    assign pos_row    = row_q;
    assign pos_col    = col_q;
    assign step_count = cnt_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_path_follower.sv
// Self-checking bench for path_follower: directed scenarios then random beats,
// compared against a coordinate-arithmetic model of the walk.
module tb_path_follower;

    localparam int ROW_BITS = 4;
    localparam int COL_BITS = 4;
    localparam int TB_MAX   = 4;
    localparam int CW       = 3;
    localparam int ROWS     = 1 << ROW_BITS;
    localparam int COLS     = 1 << COL_BITS;

`ifdef PATH_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic [ROW_BITS-1:0] start_row;
    logic [COL_BITS-1:0] start_col;
    logic                in_valid;
    logic [1:0]          in_dir;
    logic                in_last;
    logic                in_ready;
    logic                pos_valid;
    logic [ROW_BITS-1:0] pos_row;
    logic [COL_BITS-1:0] pos_col;
    logic [CW-1:0]       step_count;
    logic                done;
    logic                error;

    int checks = 0;
    int errors = 0;

    // Model: run status as words, position as plain integers.
    bit m_running, m_finished, m_aborted;
    int m_row, m_col, m_cnt;
    bit m_pv;

    path_follower #(
        .ROW_BITS  (ROW_BITS),
        .COL_BITS  (COL_BITS),
        .WIDTH     (2),
        .MAX_STEPS (TB_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_row  (start_row),
        .start_col  (start_col),
        .in_valid   (in_valid),
        .in_dir     (in_dir),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .pos_valid  (pos_valid),
        .pos_row    (pos_row),
        .pos_col    (pos_col),
        .step_count (step_count),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_running = 0; m_finished = 0; m_aborted = 0;
        m_row = 0; m_col = 0; m_cnt = 0; m_pv = 0;
    endtask

    task automatic modelEdge(input bit st, input int sr, input int sc,
                             input bit v, input int d, input bit l);
        int nr, nc;
        m_pv = 0;
        if (st) begin
            m_running = 1; m_finished = 0; m_aborted = 0;
            m_row = sr; m_col = sc; m_cnt = 0;
        end else if (m_running && v) begin
            nr = m_row + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
            nc = m_col + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
            if (m_cnt == TB_MAX || (BC && (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS))) begin
                m_running = 0; m_aborted = 1;
            end else begin
                m_row = (nr + ROWS) % ROWS;
                m_col = (nc + COLS) % COLS;
                m_cnt = m_cnt + 1;
                m_pv  = 1;
                if (l) begin
                    m_running = 0; m_finished = 1;
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ":pos_valid"}, pos_valid, m_pv);
        checkOutput({tag, ":pos_row"}, pos_row, m_row);
        checkOutput({tag, ":pos_col"}, pos_col, m_col);
        checkOutput({tag, ":step_count"}, step_count, m_cnt);
        checkOutput({tag, ":done"}, done, m_finished);
        checkOutput({tag, ":error"}, error, m_aborted);
    endtask

    // Drive one cycle of inputs, check ready before the edge and all outputs after.
    task automatic applyStimulus(input string tag, input bit st, input int sr, input int sc,
                                 input bit v, input int d, input bit l);
        start     = st;
        start_row = ROW_BITS'(sr);
        start_col = COL_BITS'(sc);
        in_valid  = v;
        in_dir    = 2'(d);
        in_last   = l;
        #1;
        checkOutput({tag, ":in_ready"}, in_ready, m_running && !st);
        @(posedge clk);
        modelEdge(st, sr, sc, v, d, l);
        #1;
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        checkOutput({tag, ":in_ready"}, in_ready, 0);
        start = 0; in_valid = 0; in_last = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; start_row = 0; start_col = 0;
        in_valid = 0; in_dir = 0; in_last = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset:in_ready", in_ready, 0);
        rst = 1'b0;

        $display("[TB] basic walk");
        applyStimulus("walk_start", 1, 5, 5, 0, 0, 0);
        applyStimulus("walk1", 0, 0, 0, 1, 1, 0);
        applyStimulus("walk2", 0, 0, 0, 1, 1, 0);
        applyStimulus("walk3", 0, 0, 0, 1, 2, 0);
        applyStimulus("walk4", 0, 0, 0, 1, 3, 1);
        applyStimulus("walk_hold", 0, 0, 0, 1, 1, 0);

        $display("[TB] stalls");
        applyStimulus("stall_start", 1, 0, 0, 0, 2, 0);
        applyStimulus("stall1", 0, 0, 0, 1, 2, 0);
        applyStimulus("stall2", 0, 0, 0, 0, 2, 0);
        applyStimulus("stall3", 0, 0, 0, 0, 2, 0);
        applyStimulus("stall4", 0, 0, 0, 1, 2, 0);

        $display("[TB] boundary");
        applyStimulus("bound_start", 1, 0, 3, 0, 0, 0);
        applyStimulus("bound_up", 0, 0, 0, 1, 0, 0);
        applyStimulus("bound_after", 0, 0, 0, 0, 0, 0);

        $display("[TB] overflow");
        applyStimulus("ovf_start", 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("ovf_beat%0d", i), 0, 0, 0, 1, 1, 0);
        end

        $display("[TB] restart and reset");
        applyStimulus("rs_start", 1, 1, 1, 0, 0, 0);
        applyStimulus("rs_beat1", 0, 0, 0, 1, 2, 0);
        applyStimulus("rs_beat2", 0, 0, 0, 1, 1, 0);
        applyStimulus("rs_restart", 1, 7, 8, 1, 1, 0);
        applyStimulus("rs_beat3", 0, 0, 0, 1, 3, 0);
        asyncReset("rs_async");

        $display("[TB] restart from done");
        applyStimulus("rd_start", 1, 3, 3, 0, 0, 0);
        applyStimulus("rd_last", 0, 0, 0, 1, 0, 1);
        applyStimulus("rd_restart", 1, 9, 2, 0, 0, 0);
        applyStimulus("rd_beat", 0, 0, 0, 1, 2, 0);

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncReset("rand_rst");
            end else begin
                applyStimulus("rand",
                              ($urandom_range(0, 11) == 0),
                              int'($urandom_range(0, ROWS - 1)),
                              int'($urandom_range(0, COLS - 1)),
                              ($urandom_range(0, 3) != 0),
                              int'($urandom_range(0, 3)),
                              ($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/path_follower.md
Name: path_follower

Overview:
- Consumer of the recorded-move stream produced by the solver's move list during read-out.
- Takes 2-bit direction codes one per handshake, starts from a given cell, and walks the maze grid.
- Emits the cell coordinate reached after every move, plus a step count.
- Reports completion on the last move, or an error on grid exit or step overflow; feeds the path display/check logic.

Parameters:
- ROW_BITS, 4, width of the row coordinate; grid has 2^ROW_BITS rows.
- COL_BITS, 4, width of the column coordinate; grid has 2^COL_BITS columns.
- WIDTH, 2, width of a direction code.
- MAX_STEPS, 256, maximum number of moves accepted per run.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a run; latches start_row/start_col
- start_row  input  ROW_BITS  initial row
- start_col  input  COL_BITS  initial column
- in_valid  input  1  direction beat valid
- in_dir  input  WIDTH  direction code
- in_last  input  1  marks the final beat of the path
- in_ready  output  1  block accepts a beat this cycle
- pos_valid  output  1  one-cycle pulse; pos_row/pos_col updated
- pos_row  output  ROW_BITS  current row
- pos_col  output  COL_BITS  current column
- step_count  output  clog2(MAX_STEPS+1)  moves accepted this run
- done  output  1  level; run finished normally
- error  output  1  level; run aborted

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- Direction encoding:
  - 00 up: row-1
  - 01 right: col+1
  - 10 down: row+1
  - 11 left: col-1
- Registered FSM, states IDLE, RUN, DONE, ERR.
- IDLE:
  - in_ready=0.
  - On start: pos_row/pos_col <= start_row/start_col; step_count <= 0; done, error <= 0; next state RUN.
  - No pos_valid pulse for the start cell.
- RUN:
  - in_ready=1 combinationally, except when start is high.
  - A beat is accepted when in_valid && in_ready.
  - Accepted beat: position updated at the same edge; pos_valid=1 for exactly the following cycle; step_count+1.
  - Latency from accept edge to visible new position: 1 cycle.
  - Accepted beat with in_last=1: apply the move, then go to DONE; done=1 from the next cycle.
  - Beat accepted while step_count==MAX_STEPS: go to ERR; position and count unchanged; no pos_valid.
  - in_valid low: hold all state; pos_valid=0.
- DONE / ERR:
  - in_ready=0; outputs hold; done or error held high.
  - start restarts the run exactly as from IDLE.
- start in RUN: aborts the current run and restarts. Any beat offered in that cycle is not accepted (in_ready=0).
- Async rst mid-run: immediate return to the reset values; any partial path is discarded.
- Arithmetic: coordinate update is modulo 2^ROW_BITS / 2^COL_BITS unless the optional feature is enabled.

Optional Feature:
- Macro: PATH_BOUND_CHECK_EN.
- Defined:
  - A move leaving the grid (row 0 up, row max down, col 0 left, col max right) goes to ERR.
  - Position and step_count are unchanged; no pos_valid pulse.
  - error=1 from the next cycle.
- Undefined: coordinates wrap silently; the error state is reachable only by step overflow.

Decomposition:
- Shared package maze_pkg:
  - direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11
  - FSM state encoding (IDLE, RUN, DONE, ERR)
  - BITS() width helper
- One natural sub-module: move_unit.
  - Purely combinational.
  - Inputs: row, col, dir. Outputs: next_row, next_col, out_of_bounds.
  - Instantiated once; path_follower holds the FSM and registers.

Test Plan:
- Basic walk: reset; start at (5,5); beats 01,01,10,11(last) → positions (5,6),(5,7),(6,7),(6,6); four pos_valid pulses; step_count=4; done=1; error=0.
- Stalls: in_valid toggled 1,0,0,1 with dir=10 from (0,0) → positions (1,0) then (2,0); no pos_valid on idle cycles; step_count=2.
- Boundary: start (0,3), dir 00.
  - With PATH_BOUND_CHECK_EN: error=1; position stays (0,3); step_count=0.
  - Without: position (15,3); run continues.
- Overflow: MAX_STEPS=4; six beats of 01 from (0,0) → four moves to (0,4); fifth beat → error=1; in_ready=0 afterwards.
- Restart and reset: start mid-run after 2 moves → position reloads the new start, step_count=0; async rst asserted between edges → all outputs 0 immediately.
- Restart from DONE: after a completed run, start at (9,2) → done clears next cycle; in_ready=1; first beat 10 → (10,2).
